// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage:
//               FSM state encoding, PC step, NOP filler and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch control FSM states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // Default PC / instruction-memory byte-address width
    localparam int ADDR_W_DEFAULT = 8;

    // Default instruction width
    localparam int DATA_W_DEFAULT = 32;

    // Default fetch counter width
    localparam int CNT_W_DEFAULT = 16;

    // Byte distance between consecutive instruction words
    localparam int PC_STEP = 4;

    // Bubble value presented to decode when the IF/ID register is empty
    // (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen
// Description : Program counter for the fetch stage. Holds the PC, selects
//               between hold / +PC_STEP / word-aligned redirect target, and
//               flags when the next sequential step wraps the address space.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance_i,         // a fetch consumed the current pc
    input  logic              redirect_valid_i,  // load redirect target (wins over advance)
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              wrap_o             // pc + PC_STEP overflows ADDR_W
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic              pc_carry;
    logic [ADDR_W-1:0] redirect_aligned;
    logic [1:0]        redirect_lsbs_unused;

    // Sequential increment with carry-out; the carry marks a wrap to zero.
    assign {pc_carry, pc_inc} = {1'b0, pc_q} + (ADDR_W + 1)'(PC_STEP);

    // Redirect targets are forced to a word boundary; the low bits are dropped.
    assign redirect_aligned     = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign redirect_lsbs_unused = redirect_pc_i[1:0];

    // Next-PC select: redirect has priority, then sequential advance, else hold.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_aligned;
        end else if (advance_i) begin
            pc_d = pc_inc;
        end
    end

    // PC register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o   = pc_q;
    assign wrap_o = pc_carry;

endmodule : fetch_pc_gen
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage in front of a combinational-read instruction
//               memory. Owns the start/run/halt FSM, the IF/ID pipeline
//               register with valid/ready handshake toward decode, branch
//               redirect with flush, wrap pulse and a saturating fetch count.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = fetch_pkg::ADDR_W_DEFAULT,
    parameter int                DATA_W    = fetch_pkg::DATA_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(fetch_pkg::NOP_INSTR),
    parameter int                CNT_W     = fetch_pkg::CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    // run control
    input  logic              start_i,
    input  logic              halt_i,
    // branch / jump redirect
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    // instruction memory
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_instr_i,
    // IF/ID register toward decode
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [DATA_W-1:0] id_instr_o,
    output logic [ADDR_W-1:0] id_pc_o,
    // status
    output logic              busy_o,
    output logic              wrap_o,
    output logic [CNT_W-1:0]  fetch_count_o
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    fetch_state_e      state_q;
    logic              busy_q;

    logic              id_valid_q;
    logic              id_valid_d;
    logic [DATA_W-1:0] id_instr_q;
    logic [DATA_W-1:0] id_instr_d;
    logic [ADDR_W-1:0] id_pc_q;
    logic [ADDR_W-1:0] id_pc_d;

    logic              wrap_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic [ADDR_W-1:0] pc;
    logic              pc_wraps;
    logic              slot_free;
    logic              fire;
    logic              start_req;

    // ------------------------------------------------------------------------
    // Fetch qualification
    // ------------------------------------------------------------------------
    // The IF/ID slot can take a new word if it is empty or being drained now.
    assign slot_free = !id_valid_q || id_ready_i;

    // A fetch happens only while running, with no halt or redirect this cycle.
    assign fire = (state_q == ST_RUN) && !halt_i && !redirect_valid_i && slot_free;

    // halt_i overrides start_i whenever both are asserted.
    assign start_req = start_i && !halt_i;

    // ------------------------------------------------------------------------
    // PC generator
    // ------------------------------------------------------------------------
    fetch_pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk              (clk),
        .rst_n            (rst_n),
        .advance_i        (fire),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pc_o             (pc),
        .wrap_o           (pc_wraps)
    );

    // The memory read is side-effect free, so the address simply tracks pc,
    // including while stalled.
    assign imem_addr_o = pc;

    // ------------------------------------------------------------------------
    // Run-control FSM with registered busy output
    // ------------------------------------------------------------------------
    // Moves IDLE/HALT -> RUN on start, RUN -> HALT on halt; busy mirrors RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (halt_i) begin
                        state_q <= ST_HALT;
                        busy_q  <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (start_req) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // IF/ID register next state
    // ------------------------------------------------------------------------
    // Priority: redirect flush, then new fetch, then drain to bubble; otherwise
    // hold (covers backpressure, where nothing may change).
    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        if (redirect_valid_i) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (fire) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_instr_i;
            id_pc_d    = pc;
        end else if (id_valid_q && id_ready_i) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end
    end

    // Saturating fetch counter: stops at all-ones instead of rolling over.
    always_comb begin
        cnt_d = cnt_q;
        if (fire && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // IF/ID register, wrap pulse and fetch counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
            wrap_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            wrap_q     <= fire && pc_wraps;
            cnt_q      <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign id_valid_o    = id_valid_q;
    assign id_instr_o    = id_instr_q;
    assign id_pc_o       = id_pc_q;
    assign busy_o        = busy_q;
    assign wrap_o        = wrap_q;
    assign fetch_count_o = cnt_q;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit with a 64-word
//               instruction memory model and an expected-PC scoreboard that
//               is consumed on every decode handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        halt_i;
    logic        redirect_valid_i;
    logic [7:0]  redirect_pc_i;
    logic [7:0]  imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [7:0]  id_pc_o;
    logic        busy_o;
    logic        wrap_o;
    logic [15:0] fetch_count_o;

    logic [31:0] mem [64];
    logic [7:0]  sb [$];
    logic [7:0]  sb_exp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_instr_i = mem[imem_addr_o[7:2]];

    instr_fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start_i),
        .halt_i           (halt_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_addr_o      (imem_addr_o),
        .imem_instr_i     (imem_instr_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_instr_o       (id_instr_o),
        .id_pc_o          (id_pc_o),
        .busy_o           (busy_o),
        .wrap_o           (wrap_o),
        .fetch_count_o    (fetch_count_o)
    );

    // Scoreboard: every accepted instruction must be the next expected PC with
    // the memory word stored at that PC.
    always @(negedge clk) begin
        if (rst_n && id_valid_o && id_ready_i) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no transfer", id_pc_o, id_instr_o);
            end else begin
                sb_exp = sb.pop_front();
                if (id_pc_o !== sb_exp) begin
                    n_fail++;
                    $display("FAIL sb_pc: got %h, required %h", id_pc_o, sb_exp);
                end
                n_checks++;
                if (id_instr_o !== mem[sb_exp[7:2]]) begin
                    n_fail++;
                    $display("FAIL sb_instr: got %h, required %h (pc %h)", id_instr_o, mem[sb_exp[7:2]], sb_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (id_valid_o !== 1'b0 || id_instr_o !== NOP || id_pc_o !== 8'h00 ||
            wrap_o !== 1'b0 || fetch_count_o !== 16'h0 || busy_o !== 1'b0 || imem_addr_o !== 8'h00) begin
            n_fail++;
            $display("FAIL %s: got v=%b instr=%h pc=%h wrap=%b cnt=%0d busy=%b addr=%h, required 0 %h 00 0 0 0 00",
                     tag, id_valid_o, id_instr_o, id_pc_o, wrap_o, fetch_count_o, busy_o, imem_addr_o, NOP);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        check_reset_values("reset_values");
        rst_n = 1'b1;
        step();
        n_checks++;
        if (id_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_fetch: got v=%b busy=%b, required 0 0", id_valid_o, busy_o);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 8; i++) sb.push_back(8'(4 * i));
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_busy: got %b, required 1", busy_o);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (id_valid_o !== 1'b1 || id_pc_o !== 8'(4 * i) || fetch_count_o !== 16'(i + 1)) begin
                n_fail++;
                $display("FAIL seq_fetch[%0d]: got v=%b pc=%h cnt=%0d, required 1 %h %0d",
                         i, id_valid_o, id_pc_o, fetch_count_o, 8'(4 * i), i + 1);
            end
        end
        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || id_valid_o !== 1'b0 || imem_addr_o !== 8'h20) begin
            n_fail++;
            $display("FAIL seq_halt: got busy=%b v=%b addr=%h, required 0 0 20", busy_o, id_valid_o, imem_addr_o);
        end
    endtask

    task automatic test_backpressure();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 8'h00;
        step();
        redirect_valid_i = 1'b0;
        start_i          = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) sb.push_back(8'(4 * i));
        step();
        step();
        step();
        n_checks++;
        if (id_pc_o !== 8'h08) begin
            n_fail++;
            $display("FAIL bp_pre: got pc=%h, required 08", id_pc_o);
        end
        id_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (id_valid_o !== 1'b1 || id_pc_o !== 8'h08 || id_instr_o !== mem[2] || imem_addr_o !== 8'h0C) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b pc=%h instr=%h addr=%h, required 1 08 %h 0c",
                         i, id_valid_o, id_pc_o, id_instr_o, imem_addr_o, mem[2]);
            end
        end
        id_ready_i = 1'b1;
        step();
        n_checks++;
        if (id_pc_o !== 8'h0C || id_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b pc=%h, required 1 0c", id_valid_o, id_pc_o);
        end
        step();
        step();
        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
        n_checks++;
        if (id_valid_o !== 1'b0 || imem_addr_o !== 8'h18) begin
            n_fail++;
            $display("FAIL bp_drain: got v=%b addr=%h, required 0 18", id_valid_o, imem_addr_o);
        end
    endtask

    task automatic test_redirect();
        sb.push_back(8'h18);
        sb.push_back(8'h1C);
        sb.push_back(8'h40);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 8'h43;
        step();
        redirect_valid_i = 1'b0;
        n_checks++;
        if (id_valid_o !== 1'b0 || id_instr_o !== NOP || imem_addr_o !== 8'h40) begin
            n_fail++;
            $display("FAIL redir_flush: got v=%b instr=%h addr=%h, required 0 %h 40", id_valid_o, id_instr_o, imem_addr_o, NOP);
        end
        step();
        n_checks++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 8'h40 || id_instr_o !== 32'h4d26a813) begin
            n_fail++;
            $display("FAIL redir_target: got v=%b pc=%h instr=%h, required 1 40 4d26a813", id_valid_o, id_pc_o, id_instr_o);
        end
        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [4];
        logic       exp_wrap [4];
        exp_pc   = '{8'hF8, 8'hFC, 8'h00, 8'h04};
        exp_wrap = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) sb.push_back(exp_pc[i]);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 8'hF8;
        start_i          = 1'b1;
        step();
        redirect_valid_i = 1'b0;
        start_i          = 1'b0;
        n_checks++;
        if (imem_addr_o !== 8'hF8 || busy_o !== 1'b1 || wrap_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_setup: got addr=%h busy=%b wrap=%b, required f8 1 0", imem_addr_o, busy_o, wrap_o);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (id_pc_o !== exp_pc[i] || wrap_o !== exp_wrap[i]) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got pc=%h wrap=%b, required %h %b", i, id_pc_o, wrap_o, exp_pc[i], exp_wrap[i]);
            end
        end
        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
        n_checks++;
        if (fetch_count_o !== 16'd21 || wrap_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_count: got cnt=%0d wrap=%b, required 21 0", fetch_count_o, wrap_o);
        end
    endtask

    task automatic test_halt();
        sb.push_back(8'h08);
        start_i = 1'b1;
        step();
        start_i    = 1'b0;
        id_ready_i = 1'b0;
        step();
        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || id_valid_o !== 1'b1 || id_pc_o !== 8'h08) begin
            n_fail++;
            $display("FAIL halt_hold: got busy=%b v=%b pc=%h, required 0 1 08", busy_o, id_valid_o, id_pc_o);
        end
        step();
        n_checks++;
        if (id_valid_o !== 1'b1 || id_instr_o !== mem[2] || imem_addr_o !== 8'h0C) begin
            n_fail++;
            $display("FAIL halt_stable: got v=%b instr=%h addr=%h, required 1 %h 0c", id_valid_o, id_instr_o, imem_addr_o, mem[2]);
        end
        id_ready_i = 1'b1;
        step();
        step();
        n_checks++;
        if (id_valid_o !== 1'b0 || imem_addr_o !== 8'h0C || fetch_count_o !== 16'd22) begin
            n_fail++;
            $display("FAIL halt_drain: got v=%b addr=%h cnt=%0d, required 0 0c 22", id_valid_o, imem_addr_o, fetch_count_o);
        end
        start_i = 1'b1;
        halt_i  = 1'b1;
        step();
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_priority: got busy=%b, required 0", busy_o);
        end
        halt_i = 1'b0;
        step();
        start_i    = 1'b0;
        id_ready_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_resume: got busy=%b, required 1", busy_o);
        end
        step();
        n_checks++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 8'h0C || id_instr_o !== mem[3]) begin
            n_fail++;
            $display("FAIL halt_resume_pc: got v=%b pc=%h instr=%h, required 1 0c %h", id_valid_o, id_pc_o, id_instr_o, mem[3]);
        end
    endtask

    task automatic test_reset_midrun();
        n_checks++;
        if (id_valid_o !== 1'b1 || fetch_count_o !== 16'd23 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got v=%b cnt=%0d busy=%b, required 1 23 1", id_valid_o, fetch_count_o, busy_o);
        end
        rst_n = 1'b0;
        step();
        check_reset_values("midrun_reset");
        sb.delete();
        rst_n      = 1'b1;
        id_ready_i = 1'b1;
        step();
        step();
        n_checks++;
        if (id_valid_o !== 1'b0 || busy_o !== 1'b0 || fetch_count_o !== 16'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got v=%b busy=%b cnt=%0d, required 0 0 0", id_valid_o, busy_o, fetch_count_o);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h1000_0000 + (32'(i) * 32'h0101_0107);
        end
        mem[0]  = 32'h0000_7033;
        mem[1]  = 32'h0010_0093;
        mem[16] = 32'h4d26_a813;

        rst_n            = 1'b0;
        start_i          = 1'b0;
        halt_i           = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 8'h00;
        id_ready_i       = 1'b1;

        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_midrun();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending entries, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
